// File: rtl/delay_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delay_buf: multi-tap circular delay buffer with fill-qualified tap valids. |
// | Optional DELAY_BUF_ZERO_FILL_EN zeroes invalid taps. Revision: 1.0         |
// +--------------------------------------------------------------------------+
module delay_buf #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_TAPS      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              clr,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic [NUM_TAPS*ADDRESS_WIDTH-1:0] offset,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]    dout,
  output logic [NUM_TAPS-1:0]               dout_valid,
  output logic [ADDRESS_WIDTH-1:0]          wr_ptr
);

  localparam int                     c_DEPTH    = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] c_PTR_ONE  = 1;
  localparam logic [ADDRESS_WIDTH:0]   c_FILL_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   c_FILL_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0]          mem_q [c_DEPTH];
  logic [ADDRESS_WIDTH-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH:0]         fill_q, fill_d;
  logic [NUM_TAPS*DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NUM_TAPS-1:0]            valid_q, valid_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    fill_d   = (fill_q == c_FILL_MAX) ? fill_q : fill_q + c_FILL_ONE;
  end

  // Taps read the pre-write contents; a non-zero offset never aliases wr_ptr_q.
  genvar k;
  generate
    for (k = 0; k < NUM_TAPS; k++) begin : g_tap
      logic [ADDRESS_WIDTH-1:0] w_off;
      logic [ADDRESS_WIDTH-1:0] w_rd_addr;
      logic [DATA_WIDTH-1:0]    w_rd_data;
      logic                     w_bypass;
      logic                     w_valid;

      assign w_off      = offset[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign w_rd_addr  = wr_ptr_q - w_off;
      assign w_rd_data  = mem_q[w_rd_addr];
      assign w_bypass   = (w_off == '0);
      assign w_valid    = w_bypass || (fill_q >= {1'b0, w_off});
      assign valid_d[k] = w_valid;
`ifdef DELAY_BUF_ZERO_FILL_EN
      assign dout_d[k*DATA_WIDTH +: DATA_WIDTH] =
          w_bypass ? din : (w_valid ? w_rd_data : '0);
`else
      assign dout_d[k*DATA_WIDTH +: DATA_WIDTH] = w_bypass ? din : w_rd_data;
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      dout_q   <= '0;
      valid_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= '0;
    end else if (en) begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is deliberately unreset; only the fill count decides validity.
  always_ff @(posedge clk) begin
    if (en && !clr && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign wr_ptr     = wr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_delay_buf: self-checking bench for delay_buf (8/8/2 configuration).    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_delay_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  din = '0;
  logic [15:0] offset = '0;
  logic [15:0] dout;
  logic [1:0]  dout_valid;
  logic [7:0]  wr_ptr;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  delay_buf #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .NUM_TAPS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .din        (din),
    .offset     (offset),
    .dout       (dout),
    .dout_valid (dout_valid),
    .wr_ptr     (wr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream history since the last reset/clear: hist[j] is the j-th written sample.
  logic [7:0] hist [0:1023];
  int         n = 0;
  logic [7:0] m_dout  [2];
  bit         m_val   [2];
  bit         m_known [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0;
      for (int t = 0; t < 2; t++) begin
        m_dout[t] = 8'h00; m_val[t] = 1'b0; m_known[t] = 1'b1;
      end
    end else if (clr) begin
      n = 0;
      for (int t = 0; t < 2; t++) m_val[t] = 1'b0;
    end else if (en) begin
      for (int t = 0; t < 2; t++) begin
        int o;
        o = int'(offset[t*8 +: 8]);
        if (o == 0) begin
          m_dout[t] = din; m_val[t] = 1'b1; m_known[t] = 1'b1;
        end else if (n >= o) begin
          m_dout[t] = hist[n-o]; m_val[t] = 1'b1; m_known[t] = 1'b1;
        end else begin
          m_val[t] = 1'b0;
`ifdef DELAY_BUF_ZERO_FILL_EN
          m_dout[t] = 8'h00; m_known[t] = 1'b1;
`else
          m_known[t] = 1'b0;
`endif
        end
      end
      if (n < 1024) hist[n] = din;
      n++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int t = 0; t < 2; t++) begin
        chk($sformatf("model_valid%0d", t), int'(dout_valid[t]), int'(m_val[t]));
        if (m_known[t])
          chk($sformatf("model_dout%0d", t), int'(dout[t*8 +: 8]), int'(m_dout[t]));
      end
      chk("model_wr_ptr", int'(wr_ptr), n % 256);
    end
  end

  task automatic step(input bit e, input bit c, input int d, input int o0, input int o1);
    en     = e;
    clr    = c;
    din    = d[7:0];
    offset = {o1[7:0], o0[7:0]};
    @(posedge clk);
    #1;
  endtask

  task automatic scn_basic();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, i, 0, 3);
      if (i == 0) begin
        chk("s1_first_dout0",  int'(dout[7:0]), 0);
        chk("s1_first_valid0", int'(dout_valid[0]), 1);
        chk("s1_first_valid1", int'(dout_valid[1]), 0);
      end
      if (i == 3) begin
        chk("s1_fourth_dout1",  int'(dout[15:8]), 0);
        chk("s1_fourth_valid1", int'(dout_valid[1]), 1);
      end
      if (i == 11) begin
        chk("s1_twelfth_dout0", int'(dout[7:0]), 11);
        chk("s1_twelfth_dout1", int'(dout[15:8]), 8);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    started = 1'b1;
    #2;
    chk("reset_dout",  int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_wrptr", int'(wr_ptr), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    scn_basic();

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'hEE, 0, 3);
    chk("gap_wrptr", int'(wr_ptr), 12);
    chk("gap_dout1", int'(dout[15:8]), 8);
    chk("gap_valid", int'(dout_valid), 3);
    step(1'b1, 1'b0, 12, 0, 3);
    chk("resume_dout1", int'(dout[15:8]), 9);

    step(1'b1, 1'b1, 8'hAA, 0, 1);
    chk("clr_wrptr", int'(wr_ptr), 0);
    chk("clr_valid", int'(dout_valid), 0);
    step(1'b1, 1'b0, 8'h55, 0, 1);
    chk("post_clr_valid1", int'(dout_valid[1]), 0);
    chk("post_clr_dout0",  int'(dout[7:0]), 8'h55);
    step(1'b1, 1'b0, 8'h66, 0, 1);
    chk("post_clr2_valid1", int'(dout_valid[1]), 1);
    chk("post_clr2_dout1",  int'(dout[15:8]), 8'h55);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h10 + i, 2, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_dout",  int'(dout), 0);
    chk("async_rst_valid", int'(dout_valid), 0);
    chk("async_rst_wrptr", int'(wr_ptr), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    scn_basic();

    step(1'b0, 1'b1, 0, 0, 255);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, i % 256, 0, 255);
      if (i == 254) chk("wrap_valid1_254", int'(dout_valid[1]), 0);
      if (i == 255) begin
        chk("wrap_valid1_255", int'(dout_valid[1]), 1);
        chk("wrap_dout1_255",  int'(dout[15:8]), 0);
      end
      if (i == 299) chk("wrap_dout1_299", int'(dout[15:8]), 44);
    end
    chk("wrap_wrptr", int'(wr_ptr), 44);

    #2 rst = 1'b1;
    #4 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'h77 + i, 0, 3);
      chk("zf_valid1", int'(dout_valid[1]), 0);
`ifdef DELAY_BUF_ZERO_FILL_EN
      chk("zf_dout1", int'(dout[15:8]), 0);
`endif
    end

    en = 1'b0;
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_buf.md
# delay_buf

Multi-tap circular delay buffer for the signal-generator datapath. Each accepted sample is written into a 2^ADDRESS_WIDTH-entry dual-port memory, and NUM_TAPS independent read taps return the sample written a per-tap, runtime-programmable number of strobes earlier. It sits between the waveform source (ROM/counter) and the output stage, producing phase-shifted copies of one stream. A fill counter drives per-tap valid flags, so taps never report samples that have not been written.

## Interface
- ADDRESS_WIDTH, 8: log2 of buffer depth; max delay = 2^ADDRESS_WIDTH-1 samples.
- DATA_WIDTH, 8: sample width.
- NUM_TAPS, 2: number of read taps, ≥1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe; one sample accepted per cycle with en=1.
- clr  in  1  synchronous flush of pointer/fill state.
- din  in  DATA_WIDTH  sample in.
- offset  in  NUM_TAPS*ADDRESS_WIDTH  packed per-tap delay; tap k = bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- dout  out  NUM_TAPS*DATA_WIDTH  packed per-tap delayed sample, same packing.
- dout_valid  out  NUM_TAPS  tap k holds a genuinely written sample.
- wr_ptr  out  ADDRESS_WIDTH  next write address.

## Operation
- State: wr_ptr (ADDRESS_WIDTH bits), fill (ADDRESS_WIDTH+1 bits, saturating at 2^ADDRESS_WIDTH), registered dout/dout_valid.
- Edge with clr=1: wr_ptr←0, fill←0, dout_valid←0, dout held, memory not written. clr has priority over en.
- Edge with en=1, clr=0:
  - mem[wr_ptr]←din; wr_ptr←wr_ptr+1 (mod 2^ADDRESS_WIDTH); fill←min(fill+1, 2^ADDRESS_WIDTH).
  - Per tap k, with o=offset_k and fill as it was before the edge:
    - o=0: dout_k←din (write-through bypass), dout_valid_k←1.
    - o≠0: dout_k←mem[(wr_ptr−o) mod 2^ADDRESS_WIDTH] (pre-write contents), dout_valid_k←(fill ≥ o).
- Edge with en=0, clr=0: all state and outputs hold.
- Delay is counted in strobes, not clock cycles.
- offset is sampled only at en edges; changes take effect on the next strobe, and valid is recomputed for the new value.
- o=2^ADDRESS_WIDTH−1 reads mem[wr_ptr+1], the oldest entry; it is never the entry being written.
- Memory contents are not reset; only pointer, fill and outputs are.

## Timing
- Latency: one cycle. dout/dout_valid update on the same edge that accepts the strobe.
- Reset: asynchronous, so the following take effect immediately without a clock edge: wr_ptr=0, fill=0, dout=0, dout_valid=0. Memory is untouched.
- Reset asserted mid-stream discards all history. The first strobe after release behaves as the first strobe after power-up.
- clr and en in the same cycle: the sample is dropped.
- Back-to-back en at full clock rate is supported with no stall. There is no handshake and no backpressure.

## Configuration
- DELAY_BUF_ZERO_FILL_EN defined: any tap whose computed dout_valid is 0 loads dout_k←0 instead of the memory read.
- DELAY_BUF_ZERO_FILL_EN undefined: dout_k always loads the memory read, so invalid taps may show stale or uninitialised data. Consumers must qualify with dout_valid.
- dout_valid, fill and pointer behaviour are identical in both builds.

## Test plan
All scenarios use ADDRESS_WIDTH=8, DATA_WIDTH=8, NUM_TAPS=2.

1. Basic delay. Reset, then en=1 every cycle with din=0,1,2,…, offset0=0, offset1=3.
   - After the 1st strobe: dout0=0, dout_valid0=1, dout_valid1=0.
   - After the 4th strobe (din=3): dout1=0, dout_valid1=1.
   - Thereafter dout1=dout0−3 every cycle.
2. Wrap and maximum offset. offset1=255; 300 strobes with din=i mod 256 (i from 0).
   - dout_valid1 first rises on strobe i=255 with dout1=0.
   - At i=299: dout1=44. wr_ptr=44 afterwards.
3. Strobe gaps. As in scenario 1, then hold en=0 for 5 cycles mid-stream.
   - dout, dout_valid and wr_ptr are unchanged during the gap.
   - After resuming, dout1 is still exactly the sample 3 strobes earlier.
4. clr with en. After 10 strobes, assert clr=1 and en=1 with din=0xAA in the same cycle.
   - wr_ptr=0, dout_valid=00.
   - The next strobe with offset1=1 gives dout_valid1=0 (0xAA was not written).
5. Asynchronous reset mid-stream. Assert rst between clock edges.
   - dout=0, dout_valid=0, wr_ptr=0 before the next edge.
   - After release, scenario 1 reproduces exactly.
6. Macro build. Build with DELAY_BUF_ZERO_FILL_EN, reset, 2 strobes with offset1=3.
   - dout1=0x00 and dout_valid1=0 on both strobes.
   - Without the macro, dout_valid1 is still 0 and dout1 is not checked.
